// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe round controller: owns the board, detects win/draw, keeps saturating win counters.
// Define TTT_AUTO_RESTART_EN to leave ROUND_OVER automatically after HOLD_CYCLES cycles.
module ttt_game_ctrl #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned MAX_WINS    = 10
) (
    input  logic        clk,
    input  logic        resetG,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    output logic        move_ready,
    output logic        move_err,
    input  logic        new_game,
    input  logic        clear_score,
    output logic [17:0] p,
    output logic        turn,
    output logic [3:0]  win1,
    output logic [3:0]  win2,
    output logic [1:0]  winner,
    output logic        round_over
);

    typedef enum logic [1:0] {
        S_CLEAR,
        S_PLAY,
        S_CHECK,
        S_ROUND_OVER
    } state_e;

    localparam logic [3:0] WIN_MAX = 4'(MAX_WINS);

    // Counters are 4-bit and a zero hold time would never release ROUND_OVER.
    if (HOLD_CYCLES < 1 || MAX_WINS < 1 || MAX_WINS > 15) begin : g_param_check
        $error("ttt_game_ctrl: HOLD_CYCLES or MAX_WINS out of range");
    end

`ifdef TTT_AUTO_RESTART_EN
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    logic [HOLD_W-1:0] hold_q;
`endif

    state_e      state_q;
    logic [17:0] p_q;
    logic [17:0] p_d;
    logic        turn_q;
    logic        start_player_q;
    logic        move_ready_q;
    logic        move_err_q;
    logic        round_over_q;
    logic [3:0]  win1_q;
    logic [3:0]  win2_q;
    logic [3:0]  move_cnt_q;
    logic [1:0]  winner_q;

    logic [15:0] occupied;
    logic [15:0] cell_dec;
    logic [8:0]  half;
    logic        move_legal;
    logic        line_done;

    function automatic logic has_line(input logic [8:0] b);
        return (&{b[0], b[1], b[2]}) | (&{b[3], b[4], b[5]}) | (&{b[6], b[7], b[8]}) |
               (&{b[0], b[3], b[6]}) | (&{b[1], b[4], b[7]}) | (&{b[2], b[5], b[8]}) |
               (&{b[0], b[4], b[8]}) | (&{b[2], b[4], b[6]});
    endfunction

    // Indices 9..15 read as occupied so an out-of-range cell is simply illegal.
    assign occupied   = {7'h7f, p_q[8:0] | p_q[17:9]};
    assign move_legal = ~occupied[move_cell];
    assign cell_dec   = 16'd1 << move_cell;
    assign half       = turn_q ? p_q[17:9] : p_q[8:0];
    assign line_done  = has_line(half);

    always_comb begin
        // NOTE: default assignment first so no path leaves p_d unassigned (no latch).
        p_d = p_q;
        if (turn_q) p_d[17:9] = p_q[17:9] | cell_dec[8:0];
        else        p_d[8:0]  = p_q[8:0]  | cell_dec[8:0];
    end

    // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge resetG) begin
        if (!resetG) begin
            state_q        <= S_CLEAR;
            p_q            <= '0;
            turn_q         <= 1'b0;
            start_player_q <= 1'b0;
            move_ready_q   <= 1'b0;
            move_err_q     <= 1'b0;
            round_over_q   <= 1'b0;
            win1_q         <= '0;
            win2_q         <= '0;
            move_cnt_q     <= '0;
            winner_q       <= 2'b00;
`ifdef TTT_AUTO_RESTART_EN
            hold_q         <= '0;
`endif
        end else begin
            move_err_q <= 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    p_q          <= '0;
                    move_cnt_q   <= '0;
                    winner_q     <= 2'b00;
                    turn_q       <= start_player_q;
                    move_ready_q <= 1'b1;
                    state_q      <= S_PLAY;
                end
                S_PLAY: begin
                    if (new_game) begin
                        move_ready_q <= 1'b0;
                        state_q      <= S_CLEAR;
                    end else if (move_valid && move_ready_q) begin
                        if (move_legal) begin
                            p_q          <= p_d;
                            move_cnt_q   <= move_cnt_q + 4'd1;
                            move_ready_q <= 1'b0;
                            state_q      <= S_CHECK;
                        end else begin
                            move_err_q <= 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    if (new_game) begin
                        state_q <= S_CLEAR;
                    end else if (line_done || move_cnt_q == 4'd9) begin
                        if (line_done) begin
                            winner_q <= turn_q ? 2'b10 : 2'b01;
                            if (turn_q) begin
                                if (win2_q < WIN_MAX) win2_q <= win2_q + 4'd1;
                            end else begin
                                if (win1_q < WIN_MAX) win1_q <= win1_q + 4'd1;
                            end
                        end else begin
                            winner_q <= 2'b11;
                        end
                        round_over_q   <= 1'b1;
                        start_player_q <= ~start_player_q;
`ifdef TTT_AUTO_RESTART_EN
                        hold_q         <= HOLD_LOAD;
`endif
                        state_q        <= S_ROUND_OVER;
                    end else begin
                        turn_q       <= ~turn_q;
                        move_ready_q <= 1'b1;
                        state_q      <= S_PLAY;
                    end
                end
                S_ROUND_OVER: begin
                    if (new_game) begin
                        round_over_q <= 1'b0;
                        state_q      <= S_CLEAR;
                    end
`ifdef TTT_AUTO_RESTART_EN
                    else if (hold_q == '0) begin
                        round_over_q <= 1'b0;
                        state_q      <= S_CLEAR;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
`endif
                end
                default: state_q <= S_CLEAR;
            endcase
            // Score clear overrides any increment taken on the same edge.
            if (clear_score) begin
                win1_q <= '0;
                win2_q <= '0;
            end
        end
    end

    assign p          = p_q;
    assign turn       = turn_q;
    assign move_ready = move_ready_q;
    assign move_err   = move_err_q;
    assign round_over = round_over_q;
    assign win1       = win1_q;
    assign win2       = win2_q;
    assign winner     = winner_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl; the auto-restart scenario runs when TTT_AUTO_RESTART_EN is defined.
module tb_ttt_game_ctrl;

    logic        clk;
    logic        resetG;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic        move_ready;
    logic        move_err;
    logic        new_game;
    logic        clear_score;
    logic [17:0] p;
    logic        turn;
    logic [3:0]  win1;
    logic [3:0]  win2;
    logic [1:0]  winner;
    logic        round_over;

    int checks = 0;
    int errors = 0;
    logic exp_start = 1'b0;

    ttt_game_ctrl #(.HOLD_CYCLES(4), .MAX_WINS(10)) dut (
        .clk(clk), .resetG(resetG),
        .move_valid(move_valid), .move_cell(move_cell),
        .move_ready(move_ready), .move_err(move_err),
        .new_game(new_game), .clear_score(clear_score),
        .p(p), .turn(turn), .win1(win1), .win2(win2),
        .winner(winner), .round_over(round_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetG = 1'b0;
        move_valid = 1'b0;
        new_game = 1'b0;
        clear_score = 1'b0;
        tick();
        resetG = 1'b1;
        tick();
        exp_start = 1'b0;
    endtask

    task automatic restart_round();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
    endtask

    // One accept edge; the caller ticks again to let CHECK resolve.
    task automatic present(input int c);
        for (int i = 0; i < 20 && !move_ready; i++) tick();
        checks++;
        if (move_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: move_ready=%b expected 1 before cell %0d", move_ready, c);
        end
        move_cell = 4'(c);
        move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
    endtask

    // Plays a round that O wins; clear_score optionally rides on the deciding CHECK edge.
    task automatic play_o_win(input logic clr);
        int x_first[6] = '{0, 3, 1, 4, 8, 5};
        int o_first[5] = '{3, 0, 4, 1, 5};
        int n = exp_start ? 5 : 6;
        for (int i = 0; i < n; i++) begin
            present(exp_start ? o_first[i] : x_first[i]);
            if (i == n - 1) clear_score = clr;
            tick();
            clear_score = 1'b0;
        end
        exp_start = ~exp_start;
    endtask

    task automatic test_reset();
        resetG = 1'b0;
        move_valid = 1'b0;
        move_cell = 4'd0;
        new_game = 1'b0;
        clear_score = 1'b0;
        #3;
        checks++;
        if ({p, turn, win1, win2, winner, move_err, round_over, move_ready} !== 33'd0) begin
            errors++;
            $display("FAIL reset_state: p=%h turn=%b w1=%0d w2=%0d winner=%b err=%b ro=%b rdy=%b expected all 0",
                     p, turn, win1, win2, winner, move_err, round_over, move_ready);
        end
        tick();
        resetG = 1'b1;
        tick();
        checks++;
        if (move_ready !== 1'b1 || turn !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_play: move_ready=%b turn=%b expected 1 0", move_ready, turn);
        end
    endtask

    task automatic test_win_p1();
        present(0);
        tick();
        checks++;
        if (turn !== 1'b1) begin
            errors++;
            $display("FAIL turn_toggle: turn=%b expected 1", turn);
        end
        present(3); tick();
        present(1); tick();
        present(4); tick();
        present(2);
        checks++;
        if (p !== 18'h03007 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL win_p1_board: p=%h rdy=%b expected 03007 0", p, move_ready);
        end
        tick();
        checks++;
        if (winner !== 2'b01 || win1 !== 4'd1 || win2 !== 4'd0 || round_over !== 1'b1 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL win_p1_result: winner=%b w1=%0d w2=%0d ro=%b rdy=%b expected 01 1 0 1 0",
                     winner, win1, win2, round_over, move_ready);
        end
        exp_start = ~exp_start;
    endtask

    task automatic test_draw();
        int cells[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            present(cells[i]);
            tick();
        end
        exp_start = ~exp_start;
        checks++;
        if (p !== 18'h0E58D) begin
            errors++;
            $display("FAIL draw_board: p=%h expected 0e58d", p);
        end
        checks++;
        if (winner !== 2'b11 || win1 !== 4'd0 || win2 !== 4'd0 || round_over !== 1'b1) begin
            errors++;
            $display("FAIL draw_result: winner=%b w1=%0d w2=%0d ro=%b expected 11 0 0 1",
                     winner, win1, win2, round_over);
        end
    endtask

    task automatic test_illegal();
        int bad[2] = '{0, 12};
        restart_round();
        checks++;
        if (turn !== exp_start || p !== 18'h0) begin
            errors++;
            $display("FAIL illegal_start: turn=%b p=%h expected %b 00000", turn, p, exp_start);
        end
        present(0);
        tick();
        for (int k = 0; k < 2; k++) begin
            move_cell = 4'(bad[k]);
            move_valid = 1'b1;
            tick();
            move_valid = 1'b0;
            checks++;
            if (move_err !== 1'b1 || p !== 18'h00200 || turn !== 1'b0 || move_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d: err=%b p=%h turn=%b rdy=%b expected 1 00200 0 1",
                         bad[k], move_err, p, turn, move_ready);
            end
            tick();
            checks++;
            if (move_err !== 1'b0) begin
                errors++;
                $display("FAIL illegal_%0d_pulse: err=%b expected 0", bad[k], move_err);
            end
        end
    endtask

    task automatic test_p2_wins();
        do_reset();
        for (int r = 0; r < 12; r++) begin
            logic [3:0] exp_w2;
            exp_w2 = (r + 1 > 10) ? 4'd10 : 4'(r + 1);
            if (r > 0) restart_round();
            checks++;
            if (turn !== exp_start || turn !== 1'(r % 2)) begin
                errors++;
                $display("FAIL p2_start_r%0d: turn=%b expected %b", r, turn, 1'(r % 2));
            end
            play_o_win(1'b0);
            checks++;
            if (winner !== 2'b10 || win2 !== exp_w2 || win1 !== 4'd0 || round_over !== 1'b1) begin
                errors++;
                $display("FAIL p2_win_r%0d: winner=%b w2=%0d w1=%0d ro=%b expected 10 %0d 0 1",
                         r, winner, win2, win1, round_over, exp_w2);
            end
        end
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        checks++;
        if (win1 !== 4'd0 || win2 !== 4'd0) begin
            errors++;
            $display("FAIL clear_score: w1=%0d w2=%0d expected 0 0", win1, win2);
        end
        restart_round();
        play_o_win(1'b1);
        checks++;
        if (winner !== 2'b10 || win2 !== 4'd0) begin
            errors++;
            $display("FAIL clear_vs_inc: winner=%b w2=%0d expected 10 0", winner, win2);
        end
    endtask

    task automatic test_new_game_mid();
        logic [17:0] exp_p;
        restart_round();
        present(4);
        tick();
        exp_p = exp_start ? 18'h02000 : 18'h00010;
        checks++;
        if (p !== exp_p || turn !== ~exp_start) begin
            errors++;
            $display("FAIL ng_first_move: p=%h turn=%b expected %h %b", p, turn, exp_p, ~exp_start);
        end
        move_cell = 4'd0;
        move_valid = 1'b1;
        new_game = 1'b1;
        tick();
        move_valid = 1'b0;
        new_game = 1'b0;
        checks++;
        if (p !== exp_p || move_ready !== 1'b0 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL ng_drop: p=%h rdy=%b err=%b expected %h 0 0", p, move_ready, move_err, exp_p);
        end
        tick();
        checks++;
        if (p !== 18'h0 || turn !== exp_start || move_ready !== 1'b1) begin
            errors++;
            $display("FAIL ng_clear: p=%h turn=%b rdy=%b expected 00000 %b 1", p, turn, move_ready, exp_start);
        end
    endtask

`ifdef TTT_AUTO_RESTART_EN
    task automatic test_auto_restart();
        play_o_win(1'b0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++;
            if (round_over !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle_%0d: round_over=%b expected 1", i, round_over);
            end
        end
        tick();
        checks++;
        if (round_over !== 1'b0 || move_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_to_clear: ro=%b rdy=%b expected 0 0", round_over, move_ready);
        end
        tick();
        checks++;
        if (move_ready !== 1'b1 || p !== 18'h0 || turn !== exp_start) begin
            errors++;
            $display("FAIL hold_to_play: rdy=%b p=%h turn=%b expected 1 00000 %b", move_ready, p, turn, exp_start);
        end
        play_o_win(1'b0);
        tick();
        resetG = 1'b0;
        #1;
        checks++;
        if ({p, turn, win1, win2, winner, move_err, round_over, move_ready} !== 33'd0) begin
            errors++;
            $display("FAIL reset_mid_hold: p=%h turn=%b w1=%0d w2=%0d winner=%b ro=%b rdy=%b expected all 0",
                     p, turn, win1, win2, winner, round_over, move_ready);
        end
        tick();
        resetG = 1'b1;
        tick();
        exp_start = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_win_p1();
        test_draw();
        test_illegal();
        test_p2_wins();
        test_new_game_mid();
`ifdef TTT_AUTO_RESTART_EN
        test_auto_restart();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
Name: ttt_game_ctrl

Overview:
Sequencing controller for the tic-tac-toe display datapath. Accepts cell-move requests from the current player and owns the 18-bit board vector. Detects win and draw, keeps both players' win counters and hands round restarts.
- Its p, turn, win1 and win2 outputs drive the bitmap filter's inputs of the same names directly.

Parameters:
- HOLD_CYCLES, 50000000: cycles ROUND_OVER holds the final board before auto-restart (AUTO_RESTART_EN only); minimum 1.
- MAX_WINS, 10: saturation value of each win counter; the display renders 1..10.

Ports:
- clk  in  1  system clock
- resetG  in  1  asynchronous active-low reset
- move_valid  in  1  move request from the active player
- move_cell  in  4  cell index 0..8, row-major (0 = top-left, 8 = bottom-right)
- move_ready  out  1  controller can accept a move this cycle
- move_err  out  1  one-cycle pulse: offered move rejected
- new_game  in  1  abandon or finish the round and clear the board
- clear_score  in  1  zero win1 and win2 (sampled in any state)
- p  out  18  board; p[c] = X at cell c, p[9+c] = O at cell c
- turn  out  1  0 = player 1 (X) to move, 1 = player 2 (O)
- win1  out  4  player 1 win count
- win2  out  4  player 2 win count
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw; valid in ROUND_OVER
- round_over  out  1  high while in ROUND_OVER

Behaviour:
- Reset (resetG low, async) sets: p=0, turn=0, start_player=0, win1=win2=0, winner=00, move_err=0, round_over=0, move_ready=0, state=CLEAR, move counter=0.
- States:
  - CLEAR: one cycle. p<=0, move counter<=0, winner<=00, turn<=start_player. Next state is PLAY.
  - PLAY: move_ready=1. A handshake is move_valid&move_ready.
  - A legal move (move_cell<=8 and p[move_cell]|p[9+move_cell]==0) is accepted at edge N. The bit is set in p at N (visible after N): cell bit if turn=0, cell+9 if turn=1. Move counter increments. Next state is CHECK.
  - An illegal move (cell>8 or occupied) gives move_err=1 for exactly the following cycle, with no change to p or turn; the controller stays in PLAY.
  - CHECK: move_ready=0. The current player's 9-bit half is compared against the 8 lines (3 rows, 3 columns, 2 diagonals).
    - Line complete: winner<=01/10. The matching counter increments by 1, saturating at MAX_WINS (a value already at MAX_WINS is held). Next state is ROUND_OVER.
    - Else, if the move counter is 9: winner<=11, no counter change, next state is ROUND_OVER.
    - Else: turn toggles and the controller returns to PLAY.
  - Move latency: acceptance to updated turn/winner is 2 edges.
  - ROUND_OVER: move_ready=0; round_over=1; p is frozen for display. start_player toggles on entry, so the opener alternates between rounds. new_game moves to CLEAR.
- new_game in PLAY or CHECK: the round is abandoned, no counter change, next state is CLEAR. new_game has priority over a same-cycle move handshake; that move is dropped and move_err stays 0.
- clear_score: win1 and win2 go to 0 on the next edge, in any state. If a win increment occurs on the same edge, clear wins.
- win1 and win2 are 4-bit unsigned and never exceed MAX_WINS.
- move_valid held high across cycles: one acceptance per PLAY visit. The request must be re-presented after CHECK to be evaluated again.

Optional Feature:
- Macro: TTT_AUTO_RESTART_EN.
- When defined: a down-counter loads HOLD_CYCLES-1 on entry to ROUND_OVER. On reaching 0 the controller moves to CLEAR. new_game still exits early.
- When undefined: ROUND_OVER is left only via new_game, and no hold counter is synthesised.

Test Plan:
- Reset, then moves 0,3,1,4,2:
  - Required: p=18'h03007 after the 5th move (bits 0,1,2,12,13).
  - Two cycles later: winner=01, win1=1, round_over=1, move_ready=0.
- Moves 0,1,2,4,3,5,7,6,8:
  - Required: p = X cells {0,2,3,7,8}, O cells {1,4,5,6}.
  - winner=11 after the 9th CHECK; win1 and win2 unchanged.
- In PLAY, offer cell 0 (occupied) and cell 12:
  - Required: each gives a one-cycle move_err, with p and turn unchanged.
- Twelve consecutive P2 wins, with new_game between rounds:
  - Required: win2 reads 1..10 then holds 10, and start_player alternates each round.
  - clear_score on the same edge as an increment leaves win2=0.
- new_game together with move_valid mid-round:
  - Required: the move is dropped, the next cycle is CLEAR, p=0 after it, and turn=start_player.
- TTT_AUTO_RESTART_EN with HOLD_CYCLES=4:
  - After a win, round_over stays high 4 cycles, then CLEAR, then PLAY.
  - resetG low mid-hold: all outputs are at reset values immediately.
